// File: rtl/rv_pkg.sv
// Shared RV32 encoding definitions: opcode constants, instruction formats,
// loader FSM state encoding and an opcode-to-format classifier.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_BAD
  } fmt_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic fmt_t fmt_of(input logic [6:0] op);
    fmt_t f;
    case (op)
      OP_R:              f = FMT_R;
      OP_IMM, OP_LOAD:   f = FMT_I;
      OP_STORE:          f = FMT_S;
      OP_BRANCH:         f = FMT_B;
      default:           f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Field-input handshake plus instruction-memory write port of the loader.
interface inst_encoder_loader_if #(
  parameter int CNT_W = 9
);
  logic             start_i;
  logic             valid_i;
  logic             ready_o;
  logic             last_i;
  logic [6:0]       opcode_i;
  logic [4:0]       rd_i;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic [2:0]       funct3_i;
  logic [6:0]       funct7_i;
  logic [11:0]      imm_i;
  logic             mem_we_o;
  logic             mem_ready_i;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_o;
  logic [CNT_W-1:0] count_o;
  logic             done_o;
  logic             error_o;

  modport slave (
    input  start_i, valid_i, last_i, opcode_i, rd_i, rs1_i, rs2_i,
           funct3_i, funct7_i, imm_i, mem_ready_i,
    output ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, done_o, error_o
  );

  modport master (
    output start_i, valid_i, last_i, opcode_i, rd_i, rs1_i, rs2_i,
           funct3_i, funct7_i, imm_i, mem_ready_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, done_o, error_o
  );

endinterface

// File: rtl/inst_pack.sv
// Combinational RV32 field packer (R/I/S/B) with format classification;
// unknown opcodes report FMT_BAD and produce an all-zero word.
module inst_pack
  import rv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output fmt_t        fmt
);

  always_comb begin
    fmt  = fmt_of(opcode);
    word = '0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm, rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      // imm holds a halfword offset, so imm[k] is branch offset bit k+1
      FMT_B: word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// Program loader: packs instruction fields into RV32 words and writes them
// sequentially to instruction memory from BASE_ADDR with backpressure.
module inst_encoder_loader
  import rv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  inst_encoder_loader_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data;
  logic             error;

  logic [31:0]      word;
  fmt_t             fmt;
  logic             illegal;
  logic             drain_ok;
  logic             ready;
  logic             accept;
  logic             full;
  logic             do_write;

  inst_pack u_pack (
    .opcode (bus.opcode_i),
    .rd     (bus.rd_i),
    .rs1    (bus.rs1_i),
    .rs2    (bus.rs2_i),
    .funct3 (bus.funct3_i),
    .funct7 (bus.funct7_i),
    .imm    (bus.imm_i),
    .word   (word),
    .fmt    (fmt)
  );

  // One-entry output register: a new word may enter in the same cycle the
  // current one drains.
  assign illegal  = (fmt == FMT_BAD);
  assign drain_ok = !mem_we || bus.mem_ready_i;
  assign ready    = (state == ST_LOAD) && drain_ok;
  assign accept   = ready && bus.valid_i;
  assign full     = (count == CNT_W'(DEPTH));
  assign do_write = accept && !illegal && !full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      count    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      error    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            state <= ST_LOAD;
            count <= '0;
            error <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Overflow terminates the session even without last_i
          if (accept && (bus.last_i || full)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_ok) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (accept && (illegal || full)) error <= 1'b1;

      if (do_write) begin
        mem_we   <= 1'b1;
        mem_addr <= BASE_ADDR + (32'(count) << 2);
        mem_data <= word;
        count    <= count + 1'b1;
      end else if (bus.mem_ready_i) begin
        mem_we   <= 1'b0;
      end
    end
  end

  assign bus.ready_o    = ready;
  assign bus.mem_we_o   = mem_we;
  assign bus.mem_addr_o = mem_addr;
  assign bus.mem_data_o = mem_data;
  assign bus.count_o    = count;
  assign bus.done_o     = (state == ST_DONE);
  assign bus.error_o    = error;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: a full-depth instance at address 0
// and a DEPTH=4 instance near the top of the address space.
module tb_inst_encoder_loader;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        start = 1'b0, valid = 1'b0, last = 1'b0, mem_ready = 1'b1;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [11:0] imm = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  logic [63:0] q0[$];
  logic [63:0] q4[$];

  inst_encoder_loader_if #(.CNT_W(9)) bus();
  inst_encoder_loader_if #(.CNT_W(3)) bus4();

  assign bus.start_i     = start && !sel;
  assign bus.valid_i     = valid && !sel;
  assign bus.last_i      = last;
  assign bus.opcode_i    = opcode;
  assign bus.rd_i        = rd;
  assign bus.rs1_i       = rs1;
  assign bus.rs2_i       = rs2;
  assign bus.funct3_i    = funct3;
  assign bus.funct7_i    = funct7;
  assign bus.imm_i       = imm;
  assign bus.mem_ready_i = mem_ready;

  assign bus4.start_i     = start && sel;
  assign bus4.valid_i     = valid && sel;
  assign bus4.last_i      = last;
  assign bus4.opcode_i    = opcode;
  assign bus4.rd_i        = rd;
  assign bus4.rs1_i       = rs1;
  assign bus4.rs2_i       = rs2;
  assign bus4.funct3_i    = funct3;
  assign bus4.funct7_i    = funct7;
  assign bus4.imm_i       = imm;
  assign bus4.mem_ready_i = mem_ready;

  inst_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(256), .CNT_W(9)) dut (
    .clk_i (clk), .rst_i (rst), .bus (bus)
  );

  inst_encoder_loader #(.BASE_ADDR(32'hFFFF_FFF8), .DEPTH(4), .CNT_W(3)) dut4 (
    .clk_i (clk), .rst_i (rst), .bus (bus4)
  );

  logic [31:0] cur_count;
  logic        cur_ready, cur_done, cur_error, cur_we;
  assign cur_count = sel ? 32'(bus4.count_o) : 32'(bus.count_o);
  assign cur_ready = sel ? bus4.ready_o  : bus.ready_o;
  assign cur_done  = sel ? bus4.done_o   : bus.done_o;
  assign cur_error = sel ? bus4.error_o  : bus.error_o;
  assign cur_we    = sel ? bus4.mem_we_o : bus.mem_we_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input bit which, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] e;
    int sz;
    sz = which ? q4.size() : q0.size();
    n_assert++;
    assert (sz != 0) else begin
      n_fail++;
      $error("FAIL wr%0d_unexpected: observed write %h@%h expected none", which ? 4 : 0, d, a);
    end
    if (sz != 0) begin
      e = which ? q4.pop_front() : q0.pop_front();
      $display("write dut%0d addr=%h data=%h", which ? 4 : 0, a, d);
      chk(which ? "wr4_addr" : "wr0_addr", a, e[63:32]);
      chk(which ? "wr4_data" : "wr0_data", d, e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we_o && bus.mem_ready_i) pop_check(1'b0, bus.mem_addr_o, bus.mem_data_o);
    if (bus4.mem_we_o && bus4.mem_ready_i) pop_check(1'b1, bus4.mem_addr_o, bus4.mem_data_o);
  end

  task automatic start_session();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [11:0] im, input logic lst, input logic [31:0] exp_word,
                      input bit legal);
    bit acc;
    int depth;
    logic [31:0] base, a;
    acc   = 1'b0;
    depth = sel ? 4 : 256;
    base  = sel ? 32'hFFFF_FFF8 : 32'h0;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    last = lst; valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (cur_ready) acc = 1'b1;
    end
    chk("accept", {31'b0, acc}, 32'd1);
    if (acc && legal && exp_cnt < depth) begin
      a = base + 32'(exp_cnt) * 32'd4;
      if (sel) q4.push_back({a, exp_word});
      else     q0.push_back({a, exp_word});
      exp_cnt++;
    end
    @(posedge clk); #1 valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (cur_done) seen = 1'b1;
    end
    chk(tag, {31'b0, seen}, 32'd1);
    @(negedge clk);
    chk("done_pulse", {31'b0, cur_done}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we",    {31'b0, bus.mem_we_o}, 32'd0);
    chk("rst_ready", {31'b0, bus.ready_o},  32'd0);
    chk("rst_done",  {31'b0, bus.done_o},   32'd0);
    chk("rst_error", {31'b0, bus.error_o},  32'd0);
    chk("rst_count", 32'(bus.count_o),      32'd0);
    chk("rst_addr",  bus.mem_addr_o,        32'd0);
    chk("rst_data",  bus.mem_data_o,        32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // valid_i in IDLE is ignored
    valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, cur_ready}, 32'd0);
    @(posedge clk); #1 valid = 1'b0;

    // addi x1,x0,-1
    start_session();
    send(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 1'b1, 32'hFFF0_0093, 1'b1);
    wait_done("t1_done");
    chk("t1_count", cur_count, 32'd1);
    chk("t1_error", {31'b0, cur_error}, 32'd0);
    chk("t1_empty", 32'(q0.size()), 32'd0);

    // sw x2,8(x1); beq x1,x2,+8
    start_session();
    chk("t2_count_clr", cur_count, 32'd0);
    send(OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'h008, 1'b0, 32'h0020_A423, 1'b1);
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'h004, 1'b1, 32'h0020_8463, 1'b1);
    wait_done("t2_done");
    chk("t2_count", cur_count, 32'd2);
    chk("t2_empty", 32'(q0.size()), 32'd0);

    // Backpressure: write held three cycles
    start_session();
    mem_ready = 1'b0;
    send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'h000, 1'b0, 32'h0020_81B3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_we",    {31'b0, cur_we},    32'd1);
      chk("bp_ready", {31'b0, cur_ready}, 32'd0);
      chk("bp_addr",  bus.mem_addr_o,     32'h0);
      chk("bp_data",  bus.mem_data_o,     32'h0020_81B3);
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    send(OP_LOAD, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 12'h004, 1'b1, 32'h0040_A283, 1'b1);
    wait_done("bp_done");
    chk("bp_count", cur_count, 32'd2);
    chk("bp_empty", 32'(q0.size()), 32'd0);

    // Illegal opcode between two legal words
    start_session();
    send(OP_LOAD, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 12'h004, 1'b0, 32'h0040_A283, 1'b1);
    send(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 12'h000, 1'b0, 32'h0, 1'b0);
    chk("ill_error_now", {31'b0, cur_error}, 32'd1);
    send(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFE, 1'b1, 32'hFE00_0EE3, 1'b1);
    wait_done("ill_done");
    chk("ill_count", cur_count, 32'd2);
    chk("ill_error", {31'b0, cur_error}, 32'd1);
    chk("ill_empty", 32'(q0.size()), 32'd0);

    // DEPTH=4 instance: five words, address wraps past 2^32
    sel = 1'b1;
    start_session();
    chk("ov_error_clr", {31'b0, cur_error}, 32'd0);
    send(OP_R,      5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'h000, 1'b0, 32'h0020_81B3, 1'b1);
    send(OP_IMM,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, 1'b0, 32'hFFF0_0093, 1'b1);
    send(OP_LOAD,   5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 12'h004, 1'b0, 32'h0040_A283, 1'b1);
    send(OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 12'h008, 1'b0, 32'h0020_A423, 1'b1);
    send(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 12'h004, 1'b0, 32'h0020_8463, 1'b1);
    wait_done("ov_done");
    chk("ov_count", cur_count, 32'd4);
    chk("ov_error", {31'b0, cur_error}, 32'd1);
    chk("ov_empty", 32'(q4.size()), 32'd0);
    sel = 1'b0;

    // Reset while a write is pending
    mem_ready = 1'b0;
    start_session();
    send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 12'h000, 1'b0, 32'h0020_81B3, 1'b1);
    chk("mr_we_before", {31'b0, cur_we}, 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mr_we_async", {31'b0, bus.mem_we_o}, 32'd0);
    chk("mr_ready",    {31'b0, bus.ready_o},  32'd0);
    q0.delete();
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b1;
    start_session();
    chk("mr_count_clr", cur_count, 32'd0);
    send(OP_LOAD, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 12'h004, 1'b1, 32'h0040_A283, 1'b1);
    wait_done("mr_done");
    chk("mr_count", cur_count, 32'd1);
    chk("mr_error", {31'b0, cur_error}, 32'd0);
    chk("mr_empty", 32'(q0.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test expected completion");
    $fatal(1, "watchdog");
  end

endmodule
